approx_mult_pipe: RTL and testbench

Parametrised, pipelined unsigned approximate multiplier with a runtime exact/approximate mode. In approximate mode the L least-significant multiplier rows are dropped and a single-bit compensation term is added. This generalises the fixed 8x8, L=2 truncated multiplier to arbitrary width and drop depth. It sits in the datapath library behind a valid/ready stream interface and counts approximate transactions for error-budget monitoring.

---
 rtl/approx_mult_pkg.sv | 12 +
 rtl/approx_mult_pipe_pp_rows.sv | 36 +++
 rtl/approx_mult_pipe.sv | 132 +++++++++++++
 tb/tb_approx_mult_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier datapath.
package approx_mult_pkg;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   // Product column that receives the single-bit compensation term in approximate mode.
   function automatic int unsigned comp_col(input int unsigned w, input int unsigned l);
      return w + l - 2;
   endfunction

endpackage

// File: rtl/approx_mult_pipe_pp_rows.sv
// Combinational partial-product rows RowLo..RowHi of y*x, summed into a 2W-bit value.
// In approximate mode every row below L is forced to zero.
module approx_pp_rows
   import approx_mult_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned L     = 2,
   parameter int unsigned RowLo = 0,
   parameter int unsigned RowHi = 3
) (
   input  logic [W-1:0]   x_i,
   input  logic [W-1:0]   y_i,
   input  logic           mode_i,
   output logic [2*W-1:0] sum_o
);

   logic [2*W-1:0] acc;
   logic [2*W-1:0] pp;
   logic [W-1:0]   xs;

   // Walk the multiplier bits LSB first; pp tracks y shifted to the current row.
   always_comb begin
      acc = '0;
      pp  = {{W{1'b0}}, y_i};
      xs  = x_i;
      for (int unsigned r = 0; r < W; r++) begin
         if (xs[0] && (r >= RowLo) && (r <= RowHi) && !((mode_i == MODE_APPROX) && (r < L))) begin
            acc = acc + pp;
         end
         pp = pp << 1;
         xs = xs >> 1;
      end
      sum_o = acc;
   end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined unsigned multiplier with runtime exact/approximate mode,
// valid/ready handshake on both sides and a saturating approximate-transaction counter.
module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned L     = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   z,
   output logic             out_mode,
   output logic [CNT_W-1:0] approx_cnt
);

   localparam int unsigned M       = W / 2;
   localparam int unsigned CompCol = comp_col(W, L);

   if ((L < 1) || (L > W - 1)) begin : g_bad_l
      $error("approx_mult_pipe: L must lie in 1..W-1");
   end

   logic             en;
   logic             accept;
   logic [2*W-1:0]   psum_lo_d, psum_hi_d;
   logic             comp_d;
   logic [2*W-1:0]   z_d;
   logic [CNT_W-1:0] cnt_d;

   logic             valid1_q;
   logic [2*W-1:0]   psum_lo_q, psum_hi_q;
   logic             comp_q;
   logic             mode_q;
   logic [2*W-1:0]   z_q;
   logic             out_mode_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_q;

   approx_pp_rows #(
      .W     (W),
      .L     (L),
      .RowLo (0),
      .RowHi (M - 1)
   ) u_rows_lo (
      .x_i    (x),
      .y_i    (y),
      .mode_i (mode),
      .sum_o  (psum_lo_d)
   );

   approx_pp_rows #(
      .W     (W),
      .L     (L),
      .RowLo (M),
      .RowHi (W - 1)
   ) u_rows_hi (
      .x_i    (x),
      .y_i    (y),
      .mode_i (mode),
      .sum_o  (psum_hi_d)
   );

   // Handshake control, compensation bit, final sum and counter next state.
   always_comb begin
      en     = out_ready || !out_valid_q;
      accept = in_valid && en;
      comp_d = (mode == MODE_APPROX) && x[L-1] && y[W-1];
      z_d    = psum_lo_q + psum_hi_q + ({{(2*W-1){1'b0}}, comp_q} << CompCol);
      cnt_d  = cnt_q;
      if (accept && (mode == MODE_APPROX) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Stage 1: partial sums, compensation bit and mode of the accepted operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid1_q  <= 1'b0;
         psum_lo_q <= '0;
         psum_hi_q <= '0;
         comp_q    <= 1'b0;
         mode_q    <= MODE_EXACT;
      end else if (en) begin
         valid1_q <= in_valid;
         if (accept) begin
            psum_lo_q <= psum_lo_d;
            psum_hi_q <= psum_hi_d;
            comp_q    <= comp_d;
            mode_q    <= mode;
         end
      end
   end

   // Stage 2: final product; z only updates when a real result arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         z_q         <= '0;
         out_mode_q  <= MODE_EXACT;
      end else if (en) begin
         out_valid_q <= valid1_q;
         if (valid1_q) begin
            z_q        <= z_d;
            out_mode_q <= mode_q;
         end
      end
   end

   // Saturating count of accepted approximate transactions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign in_ready   = en;
   assign out_valid  = out_valid_q;
   assign z          = z_q;
   assign out_mode   = out_mode_q;
   assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed cases, streaming, stall, async reset,
// counter saturation and a random sweep over several W/L configurations.
module tb_approx_mult_pipe;

   localparam int NSW = 9;
   localparam int NSWEEP = 60;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // Main instance, W=8 L=2 CNT_W=16
   logic        in_valid, in_ready, mode, out_valid, out_ready, out_mode;
   logic [7:0]  x, y;
   logic [15:0] z, approx_cnt;

   // Counter-saturation instance, CNT_W=3
   logic        c_in_valid, c_in_ready, c_mode, c_out_valid, c_out_mode;
   logic [7:0]  c_x, c_y;
   logic [15:0] c_z;
   logic [2:0]  c_cnt;

   // Sweep instances share these inputs, each taking its low W bits
   logic        sw_valid, sw_mode;
   logic [11:0] sw_x, sw_y;
   logic [23:0] sw_z  [NSW];
   logic        sw_ov [NSW];
   logic        sw_om [NSW];

   int errors = 0;
   int checks = 0;
   logic [63:0] q_z [$];
   logic        q_m [$];
   int cnt_model;
   int fired;
   int pops;

   function automatic int sw_w(input int i);
      if (i < 3) return 4;
      else if (i < 6) return 8;
      else return 12;
   endfunction

   function automatic int sw_l(input int i);
      case (i % 3)
         0:       return 1;
         1:       return 2;
         default: return sw_w(i) - 1;
      endcase
   endfunction

   // Reference: exact product, or truncated rows plus compensation, straight from the equation.
   function automatic logic [63:0] ref_mult(input int w, input int l, input logic [63:0] a_in,
                                            input logic [63:0] b_in, input bit m);
      logic [63:0] a, b, p, wmask, pmask;
      bit          c;
      wmask = (64'd1 << w) - 64'd1;
      pmask = (64'd1 << (2 * w)) - 64'd1;
      a = a_in & wmask;
      b = b_in & wmask;
      if (!m) begin
         p = a * b;
      end else begin
         p = (b * (a >> l)) << l;
         c = a[l-1] && b[w-1];
         p = p + (64'(c) << (w + l - 2));
      end
      return p & pmask;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One cycle on the main instance with scoreboard bookkeeping for both handshakes.
   task automatic step(input bit iv, input logic [7:0] xx, input logic [7:0] yy, input bit m,
                       input bit ordy);
      @(negedge clk);
      in_valid  = iv;
      x         = xx;
      y         = yy;
      mode      = m;
      out_ready = ordy;
      #1;
      fired = 0;
      if (out_valid && out_ready) begin
         fired = 1;
         chk("out_expected", 64'(q_z.size() != 0), 64'd1);
         if (q_z.size() != 0) begin
            chk("stream_z", 64'(z), q_z.pop_front());
            chk("stream_mode", 64'(out_mode), 64'(q_m.pop_front()));
            pops++;
         end
      end
      if (in_valid && in_ready) begin
         q_z.push_back(ref_mult(8, 2, 64'(xx), 64'(yy), m));
         q_m.push_back(m);
         if (m && cnt_model < 65535) cnt_model++;
      end
   endtask

   // Single transaction with latency check; expected product given as a constant.
   task automatic directed(input logic [7:0] xx, input logic [7:0] yy, input bit m,
                           input logic [15:0] exp_z);
      @(negedge clk);
      in_valid  = 1'b1;
      x         = xx;
      y         = yy;
      mode      = m;
      out_ready = 1'b1;
      #1;
      chk("dir_in_ready", 64'(in_ready), 64'd1);
      if (m) cnt_model++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("dir_lat1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk("dir_out_valid", 64'(out_valid), 64'd1);
      chk("dir_z", 64'(z), 64'(exp_z));
      chk("dir_out_mode", 64'(out_mode), 64'(m));
      chk("dir_cnt", 64'(approx_cnt), 64'(cnt_model));
   endtask

   approx_mult_pipe #(.W(8), .L(2), .CNT_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x          (x),
      .y          (y),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .z          (z),
      .out_mode   (out_mode),
      .approx_cnt (approx_cnt)
   );

   approx_mult_pipe #(.W(8), .L(2), .CNT_W(3)) u_dut_cnt (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (c_in_valid),
      .in_ready   (c_in_ready),
      .x          (c_x),
      .y          (c_y),
      .mode       (c_mode),
      .out_valid  (c_out_valid),
      .out_ready  (1'b1),
      .z          (c_z),
      .out_mode   (c_out_mode),
      .approx_cnt (c_cnt)
   );

   for (genvar g = 0; g < NSW; g++) begin : g_sw
      localparam int GW = sw_w(g);
      localparam int GL = sw_l(g);
      logic [2*GW-1:0] gz;
      logic            gir, gov, gom;
      logic [15:0]     gcnt;
      approx_mult_pipe #(.W(GW), .L(GL), .CNT_W(16)) u_sw (
         .clk        (clk),
         .rst        (rst),
         .in_valid   (sw_valid),
         .in_ready   (gir),
         .x          (sw_x[GW-1:0]),
         .y          (sw_y[GW-1:0]),
         .mode       (sw_mode),
         .out_valid  (gov),
         .out_ready  (1'b1),
         .z          (gz),
         .out_mode   (gom),
         .approx_cnt (gcnt)
      );
      assign sw_z[g]  = 24'(gz);
      assign sw_ov[g] = gov;
      assign sw_om[g] = gom;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  rx, ry;
      logic [11:0] hx [NSWEEP];
      logic [11:0] hy [NSWEEP];
      bit          hm [NSWEEP];
      int          c_model;

      rst = 1'b1;
      in_valid = 1'b0; x = '0; y = '0; mode = 1'b0; out_ready = 1'b1;
      c_in_valid = 1'b0; c_x = '0; c_y = '0; c_mode = 1'b0;
      sw_valid = 1'b0; sw_x = '0; sw_y = '0; sw_mode = 1'b0;
      cnt_model = 0;
      pops = 0;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_z", 64'(z), 64'd0);
      chk("rst_out_mode", 64'(out_mode), 64'd0);
      chk("rst_cnt", 64'(approx_cnt), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Directed products
      directed(8'd255, 8'd255, 1'b1, 16'd64516);
      directed(8'd255, 8'd255, 1'b0, 16'd65025);
      directed(8'd3,   8'd200, 1'b1, 16'd256);
      directed(8'd6,   8'd10,  1'b1, 16'd40);
      directed(8'd6,   8'd10,  1'b0, 16'd60);

      // Back-to-back stream of 8
      for (int i = 0; i < 10; i++) begin
         rx = 8'($urandom);
         ry = 8'($urandom);
         step(i < 8, rx, ry, 1'($urandom), 1'b1);
         if (i < 8) chk("b2b_in_ready", 64'(in_ready), 64'd1);
         if (i >= 2) chk("b2b_consecutive", 64'(fired), 64'd1);
      end
      chk("b2b_drained", 64'(q_z.size()), 64'd0);

      // Stall with a full pipeline, then release
      pops = 0;
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      rx = 8'($urandom);
      ry = 8'($urandom);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, rx, ry, 1'b1, 1'b0);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_z", 64'(z), q_z[0]);
      end
      step(1'b1, rx, ry, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      chk("stall_pops", 64'(pops), 64'd3);
      chk("stall_drained", 64'(q_z.size()), 64'd0);
      chk("stall_cnt", 64'(approx_cnt), 64'(cnt_model));

      // Asynchronous reset with two transactions in flight
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("inflight_valid", 64'(out_valid), 64'd1);
      #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_cnt", 64'(approx_cnt), 64'd0);
      chk("arst_z", 64'(z), 64'd0);
      q_z.delete();
      q_m.delete();
      cnt_model = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
         chk("post_rst_no_out", 64'(out_valid), 64'd0);
      end

      // Counter saturation at CNT_W=3; every fourth accept is exact
      c_model = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("sat_cnt", 64'(c_cnt), 64'((c_model > 7) ? 7 : c_model));
         c_in_valid = 1'b1;
         c_x = 8'($urandom);
         c_y = 8'($urandom);
         c_mode = (i % 4 != 3);
         #1;
         if (c_in_ready && c_mode) c_model++;
      end
      @(negedge clk);
      c_in_valid = 1'b0;
      chk("sat_final", 64'(c_cnt), 64'd7);

      // Random sweep across W/L configurations, continuous streaming
      for (int n = 0; n < NSWEEP + 2; n++) begin
         @(negedge clk);
         if (n >= 2) begin
            for (int i = 0; i < NSW; i++) begin
               chk("sweep_valid", 64'(sw_ov[i]), 64'd1);
               chk("sweep_z", 64'(sw_z[i]),
                   ref_mult(sw_w(i), sw_l(i), 64'(hx[n-2]), 64'(hy[n-2]), hm[n-2]));
               chk("sweep_mode", 64'(sw_om[i]), 64'(hm[n-2]));
            end
         end
         if (n < NSWEEP) begin
            hx[n] = 12'($urandom);
            hy[n] = 12'($urandom);
            hm[n] = 1'($urandom);
            sw_valid = 1'b1;
            sw_x = hx[n];
            sw_y = hy[n];
            sw_mode = hm[n];
         end else begin
            sw_valid = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
